branch_unit: RTL
================

// Module: branch_unit
// PURPOSE
// - Branch functional unit; drives the redirect interface (branch_target/is_branch) that InstructionFetch receives.
// - Accepts one issued branch from its ReservationStation and resolves it.
// - Completes the branch on CDB slot 0 (cdb_valid[0]); the ROB and all ReservationStations snoop that slot.
// - Redirects fetch only when the branch is non-speculative (ROB head), so no flush logic is needed downstream.
// PARAMETERS
// - DATA_W     16  operand / CDB value width
// - PC_W       16  program counter width
// - ROB_IDX_W  4   ROB index width (16-entry ROB)
// - PC_STEP    2   fall-through increment (byte-addressed 16-bit instructions)
// PORTS
// - clk             in   1          single clock; all state updates on posedge
// - rst_n           in   1          synchronous reset, active-low
// - in_valid        in   1          issue strobe from branch ReservationStation
// - in_opcode       in   4          branch opcode (shared package codes)
// - in_rob_idx      in   ROB_IDX_W  ROB slot of the branch
// - in_pc           in   PC_W       PC of the branch instruction
// - in_op1          in   DATA_W     absolute taken target (ra)
// - in_op2          in   DATA_W     condition operand (rb)
// - rob_head        in   ROB_IDX_W  current ROB head index
// - full            out  1          unit busy; RS must not issue
// - cdb_valid       out  1          completion broadcast (drives cdb_valid[0])
// - cdb_rob_idx     out  ROB_IDX_W  -> indices[3:0]
// - cdb_value       out  DATA_W     -> new_values[15:0]; {15'b0,taken}
// - is_branch       out  1          redirect pulse to InstructionFetch
// - branch_target   out  PC_W       redirect PC, valid with is_branch
// BEHAVIOUR
// - Reset (rst_n==0 at posedge): state=IDLE; full, cdb_valid and is_branch = 0; cdb_rob_idx, cdb_value and branch_target = 0.
//   Reset mid-operation discards the held branch with no broadcast.
// - Opcodes:
//   BR_JZ: taken iff op2==0
//   BR_JNZ: taken iff op2!=0
//   BR_JS: taken iff op2[DATA_W-1]
//   BR_JNS: taken iff !op2[DATA_W-1]
//   BR_JMP: always taken
//   Any other opcode: not taken.
// - Target = taken ? op1[PC_W-1:0] : in_pc+PC_STEP (mod 2^PC_W; wraps 16'hFFFE->16'h0000).
// - FSM states:
//   IDLE: full=0. On in_valid, latch idx/target/taken, resolve combinationally from the inputs, go to WAIT_HEAD.
//   WAIT_HEAD: full=1. Stay until rob_head==latched idx, then go to FIRE.
//     If rob_head already equals the index in the issue cycle, WAIT_HEAD still lasts one cycle (registered compare).
//   FIRE: one cycle with cdb_valid=1, is_branch=1, branch_target=latched target, full=1.
//     Next state is IDLE. The redirect fires whether or not the branch is taken.
// - Latency: issue at cycle N; earliest FIRE is cycle N+2.
// - full is asserted combinationally the cycle after accept. It deasserts in the cycle after FIRE, so back-to-back issue is possible every 3 cycles.
// - in_valid while full=1 is a protocol violation: the input is ignored and a simulation $error is raised.
// - cdb_valid and is_branch are single-cycle pulses, never held. Fetch treats is_branch as a level in the same cycle.
// - Outside FIRE, all CDB and redirect data outputs are driven to 0.
// STRUCTURE
// - Shared package branch_pkg:
//   opcode localparams BR_JZ=4'h0, BR_JNZ=4'h1, BR_JS=4'h2, BR_JNS=4'h3, BR_JMP=4'h4
//   state encoding BU_IDLE/BU_WAIT_HEAD/BU_FIRE
//   PC_STEP constant
// - Sub-module branch_resolve: purely combinational (opcode, pc, op1, op2) -> (taken, target). It is reused by a future predictor checker.
// - Top level holds the FSM and output registers only.
// TESTING
// - Reset: hold rst_n=0 for 2 cycles mid-WAIT_HEAD -> all outputs 0, full=0, no cdb_valid afterwards.
// - JZ taken: op2=0, op1=16'h0040, pc=16'h0010, idx=3, rob_head=3 -> FIRE at N+2 with target 16'h0040, cdb_value 1, cdb_rob_idx 3.
// - JNZ not taken: op2=0, pc=16'h0010 -> target 16'h0012, cdb_value 0. Also pc=16'hFFFE -> target 16'h0000.
// - Head gating: idx=5, rob_head=2 held for 10 cycles -> no pulse and full=1 throughout; rob_head->5 -> exactly one FIRE.
// - JS/JNS sign: op2=16'h8000 -> JS taken and JNS not taken; op2=16'h7FFF -> the reverse. Unknown opcode 4'hF -> not taken.
// - Back-to-back: second in_valid while full is ignored with $error; issue after full drops is accepted. Exactly one pulse per accepted branch.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch opcodes, fall-through step and branch-unit state encoding.
package branch_pkg;

  localparam logic [3:0] BR_JZ  = 4'h0;
  localparam logic [3:0] BR_JNZ = 4'h1;
  localparam logic [3:0] BR_JS  = 4'h2;
  localparam logic [3:0] BR_JNS = 4'h3;
  localparam logic [3:0] BR_JMP = 4'h4;

  localparam int unsigned BR_PC_STEP = 2;

  typedef enum logic [1:0] {
    BU_IDLE      = 2'd0,
    BU_WAIT_HEAD = 2'd1,
    BU_FIRE      = 2'd2
  } bu_state_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch condition and target computation; shared with the
// predictor checker, so it carries no state.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned PC_STEP = BR_PC_STEP
) (
  input  logic [3:0]        opcode,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic              taken,
  output logic [PC_W-1:0]   target
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      BR_JZ:   taken = (op2 == '0);
      BR_JNZ:  taken = (op2 != '0);
      BR_JS:   taken = op2[DATA_W-1];
      BR_JNS:  taken = ~op2[DATA_W-1];
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    // fall-through wraps naturally at the PC width
    target = taken ? op1[PC_W-1:0] : pc + PC_W'(PC_STEP);
  end

endmodule

// File: rtl/branch_unit.sv
// Branch functional unit: holds one resolved branch until it reaches the ROB
// head, then completes it on CDB slot 0 and redirects fetch in the same cycle.
//
// state        | meaning
// BU_IDLE      | empty, accepting an issue
// BU_WAIT_HEAD | branch held, waiting for rob_head to match its index
// BU_FIRE      | one-cycle CDB broadcast plus fetch redirect
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PC_W      = 16,
  parameter int unsigned ROB_IDX_W = 4,
  parameter int unsigned PC_STEP   = BR_PC_STEP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [3:0]           in_opcode,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [DATA_W-1:0]    in_op1,
  input  logic [DATA_W-1:0]    in_op2,
  input  logic [ROB_IDX_W-1:0] rob_head,
  output logic                 full,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [DATA_W-1:0]    cdb_value,
  output logic                 is_branch,
  output logic [PC_W-1:0]      branch_target
);

  bu_state_t              state, state_nxt;
  logic [ROB_IDX_W-1:0]   idx_q;
  logic [PC_W-1:0]        target_q;
  logic                   taken_q;
  logic                   load;
  logic                   res_taken;
  logic [PC_W-1:0]        res_target;

  branch_resolve #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .PC_STEP (PC_STEP)
  ) u_resolve (
    .opcode (in_opcode),
    .pc     (in_pc),
    .op1    (in_op1),
    .op2    (in_op2),
    .taken  (res_taken),
    .target (res_target)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BU_IDLE;
      idx_q    <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        idx_q    <= in_rob_idx;
        target_q <= res_target;
        taken_q  <= res_taken;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    full          = 1'b1;
    cdb_valid     = 1'b0;
    is_branch     = 1'b0;
    cdb_rob_idx   = '0;
    cdb_value     = '0;
    branch_target = '0;
    case (state)
      BU_IDLE: begin
        full = 1'b0;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = BU_WAIT_HEAD;
        end
      end
      // compare uses the latched index, so this state always lasts a cycle
      BU_WAIT_HEAD: begin
        if (rob_head == idx_q) state_nxt = BU_FIRE;
      end
      BU_FIRE: begin
        cdb_valid     = 1'b1;
        is_branch     = 1'b1;
        cdb_rob_idx   = idx_q;
        cdb_value     = {{(DATA_W-1){1'b0}}, taken_q};
        branch_target = target_q;
        state_nxt     = BU_IDLE;
      end
      default: state_nxt = BU_IDLE;
    endcase
  end

  always @(posedge clk) begin
    assert (!(rst_n && in_valid && full))
      else $error("branch_unit: in_valid while full, issue ignored");
  end

endmodule
